// File: rtl/seven_segment_pkg.sv
// Shared definitions for the seven-segment capture path: segment patterns,
// segment bit positions and the digit-tracking state encoding.
package seven_segment_pkg;

   typedef enum logic [1:0] {
      ST_WAIT  = 2'd0,
      ST_TRACK = 2'd1,
      ST_HELD  = 2'd2
   } seg_state_t;

   localparam int SEG_A = 0;
   localparam int SEG_B = 1;
   localparam int SEG_C = 2;
   localparam int SEG_D = 3;
   localparam int SEG_E = 4;
   localparam int SEG_F = 5;
   localparam int SEG_G = 6;

   // Active-low patterns written g..a, exactly as driven onto seg_n.
   localparam logic [6:0] SEG_PAT_0 = 7'b1000000;
   localparam logic [6:0] SEG_PAT_1 = 7'b1111001;
   localparam logic [6:0] SEG_PAT_2 = 7'b0100100;
   localparam logic [6:0] SEG_PAT_3 = 7'b0110000;
   localparam logic [6:0] SEG_PAT_4 = 7'b0011001;
   localparam logic [6:0] SEG_PAT_5 = 7'b0010010;
   localparam logic [6:0] SEG_PAT_6 = 7'b0000010;
   localparam logic [6:0] SEG_PAT_7 = 7'b1111000;
   localparam logic [6:0] SEG_PAT_8 = 7'b0000000;
   localparam logic [6:0] SEG_PAT_9 = 7'b0011000;
   localparam logic [6:0] SEG_PAT_A = 7'b0001000;
   localparam logic [6:0] SEG_PAT_B = 7'b0000011;
   localparam logic [6:0] SEG_PAT_C = 7'b1000110;
   localparam logic [6:0] SEG_PAT_D = 7'b0100001;
   localparam logic [6:0] SEG_PAT_E = 7'b0000110;
   localparam logic [6:0] SEG_PAT_F = 7'b0001110;

   function automatic logic [6:0] seg_encode(input logic [3:0] value);
      logic [6:0] pat;
      case (value)
         4'h0: pat = SEG_PAT_0;
         4'h1: pat = SEG_PAT_1;
         4'h2: pat = SEG_PAT_2;
         4'h3: pat = SEG_PAT_3;
         4'h4: pat = SEG_PAT_4;
         4'h5: pat = SEG_PAT_5;
         4'h6: pat = SEG_PAT_6;
         4'h7: pat = SEG_PAT_7;
         4'h8: pat = SEG_PAT_8;
         4'h9: pat = SEG_PAT_9;
         4'hA: pat = SEG_PAT_A;
         4'hB: pat = SEG_PAT_B;
         4'hC: pat = SEG_PAT_C;
         4'hD: pat = SEG_PAT_D;
         4'hE: pat = SEG_PAT_E;
         default: pat = SEG_PAT_F;
      endcase
      return pat;
   endfunction

endpackage

// File: rtl/seven_segment_decode.sv
// Combinational pattern-to-hex decoder; only the 16 exact glyphs are legal.
module seven_segment_decode
   import seven_segment_pkg::*;
(
   input  logic [6:0] i_seg_n,
   output logic [3:0] o_value,
   output logic       o_legal
);

   always_comb begin
      o_value = 4'h0;
      o_legal = 1'b1;
      case (i_seg_n)
         SEG_PAT_0: o_value = 4'h0;
         SEG_PAT_1: o_value = 4'h1;
         SEG_PAT_2: o_value = 4'h2;
         SEG_PAT_3: o_value = 4'h3;
         SEG_PAT_4: o_value = 4'h4;
         SEG_PAT_5: o_value = 4'h5;
         SEG_PAT_6: o_value = 4'h6;
         SEG_PAT_7: o_value = 4'h7;
         SEG_PAT_8: o_value = 4'h8;
         SEG_PAT_9: o_value = 4'h9;
         SEG_PAT_A: o_value = 4'hA;
         SEG_PAT_B: o_value = 4'hB;
         SEG_PAT_C: o_value = 4'hC;
         SEG_PAT_D: o_value = 4'hD;
         SEG_PAT_E: o_value = 4'hE;
         SEG_PAT_F: o_value = 4'hF;
         default:   o_legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/seven_segment_capture.sv
// Recovers hex digits from a multiplexed active-low seven-segment bus and
// presents whole frames on a valid/ready port. SEG_ERR_CNT_EN adds err_count.
module seven_segment_capture
   import seven_segment_pkg::*;
#(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [6:0]              seg_n,
   input  logic [NUM_DIGITS-1:0]   dig_en_n,
   output logic [4*NUM_DIGITS-1:0] digits_out,
   output logic [NUM_DIGITS-1:0]   digit_err,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    overrun
`ifdef SEG_ERR_CNT_EN
   ,
   output logic [15:0]             err_count
`endif
);

   localparam int         IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);
   localparam logic [7:0] CNT_MAX  = 8'(STABLE_CYCLES);

   logic [6:0]              r_seg_s1, r_seg_s2;
   logic [NUM_DIGITS-1:0]   r_den_s1, r_den_s2;
   seg_state_t              r_state, w_state_nxt;
   logic [IDX_W-1:0]        r_snap_idx, w_idx;
   logic [6:0]              r_snap_seg;
   logic [7:0]              r_cnt;
   logic [4*NUM_DIGITS-1:0] r_frame;
   logic [NUM_DIGITS-1:0]   r_seen, r_err, w_act, w_cap_bit;
   logic                    w_valid, w_same, w_cnt_hit, w_complete;
   logic                    w_snap_load, w_cnt_inc, w_capture;
   logic [3:0]              w_dec_val;
   logic                    w_dec_legal;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_seg_s1 <= '0;
         r_seg_s2 <= '0;
         r_den_s1 <= '0;
         r_den_s2 <= '0;
      end else begin
         r_seg_s1 <= seg_n;
         r_seg_s2 <= r_seg_s1;
         r_den_s1 <= dig_en_n;
         r_den_s2 <= r_den_s1;
      end
   end

   // A sample counts only while exactly one digit enable is asserted.
   assign w_act   = ~r_den_s2;
   assign w_valid = $onehot(w_act);

   always_comb begin
      w_idx = '0;
      for (int k = 0; k < NUM_DIGITS; k++)
         if (w_act[k]) w_idx = IDX_W'(k);
   end

   assign w_same    = (w_idx == r_snap_idx) && (r_seg_s2 == r_snap_seg);
   assign w_cnt_hit = (r_cnt >= CNT_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_WAIT;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_WAIT:  if (w_valid) w_state_nxt = ST_TRACK;
         ST_TRACK: begin
            if (!w_valid)       w_state_nxt = ST_WAIT;
            else if (!w_same)   w_state_nxt = ST_TRACK;
            else if (w_cnt_hit) w_state_nxt = ST_HELD;
         end
         ST_HELD: begin
            if (!w_valid)     w_state_nxt = ST_WAIT;
            else if (!w_same) w_state_nxt = ST_TRACK;
         end
         default: w_state_nxt = ST_WAIT;
      endcase
   end

   always_comb begin
      w_snap_load = 1'b0;
      w_cnt_inc   = 1'b0;
      w_capture   = 1'b0;
      case (r_state)
         ST_WAIT:  w_snap_load = w_valid;
         ST_TRACK: begin
            w_snap_load = w_valid && !w_same;
            w_cnt_inc   = w_valid && w_same;
            w_capture   = w_valid && w_same && w_cnt_hit;
         end
         ST_HELD:  w_snap_load = w_valid && !w_same;
         default:  w_snap_load = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_snap_idx <= '0;
         r_snap_seg <= '0;
         r_cnt      <= '0;
      end else if (w_snap_load) begin
         r_snap_idx <= w_idx;
         r_snap_seg <= r_seg_s2;
         r_cnt      <= 8'd1;
      end else if (w_cnt_inc && (r_cnt != CNT_MAX)) begin
         r_cnt <= r_cnt + 8'd1;
      end
   end

   // The snapshot equals the live sample whenever a capture fires.
   seven_segment_decode u_decode (
      .i_seg_n (r_snap_seg),
      .o_value (w_dec_val),
      .o_legal (w_dec_legal)
   );

   always_comb begin
      w_cap_bit = '0;
      if (w_capture) w_cap_bit[r_snap_idx] = 1'b1;
   end

   assign w_complete = &r_seen;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_frame <= '0;
         r_seen  <= '0;
         r_err   <= '0;
      end else begin
         if (w_capture) r_frame[4*r_snap_idx +: 4] <= w_dec_legal ? w_dec_val : 4'h0;
         r_seen <= (w_complete ? '0 : r_seen) | w_cap_bit;
         r_err  <= ((w_complete ? '0 : r_err) & ~w_cap_bit) | (w_dec_legal ? '0 : w_cap_bit);
      end
   end

   // A completing frame always loads; overrun flags an unread frame being lost.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         digits_out <= '0;
         digit_err  <= '0;
         out_valid  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (w_complete) begin
            digits_out <= r_frame;
            digit_err  <= r_err;
            out_valid  <= 1'b1;
            overrun    <= out_valid && !out_ready;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

`ifdef SEG_ERR_CNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         err_count <= '0;
      else if (w_capture && !w_dec_legal && (err_count != 16'hFFFF))
         err_count <= err_count + 16'd1;
   end
`endif

endmodule
